// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline-stage register with a two-entry skid buffer and flush-to-bubble.
// Define PIPE_STAGE_NEGEDGE_EN to update state on the falling clock edge instead of the rising one.
module pipe_stage_reg #(
  parameter int CTRL_W = 9,
  parameter int DATA_W = 166
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        occupancy
);
  logic              main_valid, skid_full;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, pop;
  assign in_ready  = ~skid_full;
  assign accept    = in_valid & in_ready;
  assign pop       = main_valid & out_ready;
  assign out_valid = main_valid;
  assign ctrl_out  = main_valid ? main_ctrl : '0;
  assign data_out  = main_data;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_full};
  // skid_full only ever sets while main_valid is held, so main_valid=0 implies an empty skid
`ifdef PIPE_STAGE_NEGEDGE_EN
  always_ff @(negedge clk or negedge rst_n)
`else
  always_ff @(posedge clk or negedge rst_n)
`endif
  begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
      main_data  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      skid_full  <= 1'b0;
      main_ctrl  <= '0;
      skid_ctrl  <= '0;
    end else if (!main_valid || (pop && !skid_full)) begin
      main_valid <= accept;
      if (accept) begin
        main_ctrl <= ctrl_in;
        main_data <= data_in;
      end
    end else if (pop) begin
      main_ctrl <= skid_ctrl;
      main_data <= skid_data;
      skid_full <= 1'b0;
    end else if (accept) begin
      skid_ctrl <= ctrl_in;
      skid_data <= data_in;
      skid_full <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized bench checking pipe_stage_reg against a queue-based FIFO model.
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_NEGEDGE_EN
  localparam bit NEG = 1'b1;
`else
  localparam bit NEG = 1'b0;
`endif
  typedef struct packed {
    logic [8:0]   c;
    logic [165:0] d;
  } ent_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [8:0]   ctrl_in = '0;
  logic [165:0] data_in = '0;
  logic         in_ready, out_valid;
  logic [8:0]   ctrl_out;
  logic [165:0] data_out;
  logic [1:0]   occupancy;
  wire          act_clk = NEG ? ~clk : clk;
  int           checks = 0, failures = 0;
  ent_t         q[$];
  logic [165:0] last = '0;
  int           n;
  logic         acc, pp;

  pipe_stage_reg #(.CTRL_W(9), .DATA_W(166)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .data_in(data_in), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ctrl_out(ctrl_out), .data_out(data_out), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference: a FIFO of at most two entries; output head, ready while fewer than two held
  always @(posedge act_clk) begin
    n   = q.size();
    acc = in_valid && n < 2;
    pp  = n > 0 && out_ready;
    if (!rst_n) begin
      q.delete();
      last = '0;
    end else if (flush) q.delete();
    else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back({ctrl_in, data_in});
    end
    if (q.size() > 0) last = q[0].d;
    #2;
    chk("out_valid", out_valid, q.size() > 0);
    chk("ctrl_out", ctrl_out, q.size() > 0 ? q[0].c : 9'h0);
    chk("data_out", data_out, last);
    chk("occupancy", occupancy, q.size());
    chk("in_ready", in_ready, q.size() < 2);
  end

  task automatic drive(input logic v, input logic [8:0] c, input logic [165:0] d, input logic r, input logic f);
    @(negedge act_clk);
    in_valid = v; ctrl_in = c; data_in = d; out_ready = r; flush = f;
  endtask

  task automatic after_edge;
    @(posedge act_clk);
    #3;
  endtask

  initial begin
    logic [191:0] r;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ctrl_out", ctrl_out, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_data_out", data_out, 0);
    repeat (2) @(posedge act_clk);
    drive(1, 9'h1FF, 166'd5, 1, 0);
    rst_n = 1'b1;
    #1;
    chk("no_capture_off_edge", out_valid, 0);
    after_edge();
    chk("basic_out_valid", out_valid, 1);
    chk("basic_ctrl", ctrl_out, 9'h1FF);
    chk("basic_data", data_out, 5);
    chk("basic_occ", occupancy, 1);
    for (int i = 1; i <= 8; i++) begin
      drive(1, 9'(i), 166'(i), 1, 0);
      after_edge();
      chk("stream_data", data_out, i);
      chk("stream_ready", in_ready, 1);
      chk("stream_occ", occupancy, 1);
    end
    drive(0, 0, 0, 1, 0);
    after_edge();
    chk("drained", out_valid, 0);
    drive(1, 9'h3, 166'd1, 1, 0);
    after_edge();
    drive(1, 9'h3, 166'd2, 0, 0);
    after_edge();
    chk("skid_occ", occupancy, 2);
    chk("skid_ready", in_ready, 0);
    chk("skid_head", data_out, 1);
    drive(1, 9'h3, 166'd3, 0, 0);
    after_edge();
    chk("skid_hold", data_out, 1);
    drive(1, 9'h3, 166'd3, 1, 0);
    after_edge();
    chk("bp_out2", data_out, 2);
    chk("bp_occ_after_skid", occupancy, 1);
    after_edge();
    chk("bp_out3", data_out, 3);
    drive(0, 0, 0, 1, 0);
    after_edge();
    chk("bp_empty", out_valid, 0);
    drive(1, 9'h11, 166'd10, 0, 0);
    after_edge();
    drive(1, 9'h12, 166'd11, 0, 0);
    after_edge();
    chk("fl_occ_before", occupancy, 2);
    drive(1, 9'h13, 166'd9, 1, 1);
    after_edge();
    chk("fl_valid", out_valid, 0);
    chk("fl_ctrl", ctrl_out, 0);
    chk("fl_occ", occupancy, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_data_held", data_out, 10);
    drive(0, 0, 0, 1, 0);
    after_edge();
    chk("fl_no9", out_valid, 0);
    for (int i = 0; i < 3000; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 3) != 0, 9'($urandom), r[165:0], $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0);
    end
    drive(1, 9'h55, 166'd21, 0, 0);
    after_edge();
    drive(1, 9'h56, 166'd22, 0, 0);
    after_edge();
    chk("ar_occ_before", occupancy, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_ctrl", ctrl_out, 0);
    chk("ar_data", data_out, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_ready", in_ready, 1);
    drive(0, 0, 0, 0, 0);
    @(negedge act_clk);
    rst_n = 1'b1;
    drive(1, 9'h7, 166'd42, 1, 0);
    after_edge();
    chk("post_reset_accept", data_out, 42);
    drive(0, 0, 0, 1, 0);
    repeat (2) after_edge();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
